// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: sizing, entry kind encodings
// and the operand-lookup bypass helper used for both lookup ports.
package rob_pkg;

    localparam int ROB_SIZE  = 8;
    localparam int ROB_WIDTH = 3;

    typedef enum logic [1:0] {
        ROB_KIND_REG  = 2'd0,
        ROB_KIND_BR   = 2'd1,
        ROB_KIND_ST   = 2'd2,
        ROB_KIND_HALT = 2'd3
    } rob_kind_e;

    typedef struct packed {
        logic        ready;
        logic [31:0] value;
    } lookup_t;

    // Same-cycle bypass: a live ALU broadcast wins over a live load/store
    // broadcast, which wins over whatever the entry already holds.
    function automatic lookup_t rob_lookup(
        input logic [ROB_WIDTH-1:0] id,
        input logic                 rs_ready,
        input logic [ROB_WIDTH-1:0] rs_id,
        input logic [31:0]          rs_value,
        input logic                 lsb_ready,
        input logic [ROB_WIDTH-1:0] lsb_id,
        input logic [31:0]          lsb_value,
        input logic                 stored_ready,
        input logic [31:0]          stored_value
    );
        lookup_t res;
        if (rs_ready && (rs_id == id)) begin
            res.ready = 1'b1;
            res.value = rs_value;
        end else if (lsb_ready && (lsb_id == id)) begin
            res.ready = 1'b1;
            res.value = lsb_value;
        end else begin
            res.ready = stored_ready;
            res.value = stored_value;
        end
        return res;
    endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer: allocates ids in program order, captures broadcast results,
// serves operand lookups and retires one entry per cycle from the head.
module rob
    import rob_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    output logic                 rob_full,
    output logic [ROB_WIDTH-1:0] rob_tail,
    input  logic                 dec_ready,
    input  logic [1:0]           dec_kind,
    input  logic [4:0]           dec_rd,
    input  logic [31:0]          dec_pred_pc,
    input  logic [31:0]          dec_value,
    input  logic                 dec_value_ready,
    input  logic                 rs_ready,
    input  logic [ROB_WIDTH-1:0] rs_rob_id,
    input  logic [31:0]          rs_value,
    input  logic                 lsb_ready,
    input  logic [ROB_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]          lsb_value,
    input  logic [ROB_WIDTH-1:0] qj_id,
    input  logic [ROB_WIDTH-1:0] qk_id,
    output logic                 qj_ready,
    output logic                 qk_ready,
    output logic [31:0]          qj_value,
    output logic [31:0]          qk_value,
    output logic                 commit_valid,
    output logic [4:0]           commit_rd,
    output logic [31:0]          commit_value,
    output logic [ROB_WIDTH-1:0] commit_rob_id,
    output logic                 store_commit,
    output logic [ROB_WIDTH-1:0] store_rob_id,
    output logic                 clear,
    output logic [31:0]          redirect_pc,
    output logic                 halted
);

    localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH+1)'(ROB_SIZE);

    // Entry storage
    logic        busy_q    [ROB_SIZE];
    logic        busy_d    [ROB_SIZE];
    logic [1:0]  kind_q    [ROB_SIZE];
    logic [1:0]  kind_d    [ROB_SIZE];
    logic [4:0]  rd_q      [ROB_SIZE];
    logic [4:0]  rd_d      [ROB_SIZE];
    logic        ready_q   [ROB_SIZE];
    logic        ready_d   [ROB_SIZE];
    logic [31:0] value_q   [ROB_SIZE];
    logic [31:0] value_d   [ROB_SIZE];
    logic [31:0] pred_pc_q [ROB_SIZE];
    logic [31:0] pred_pc_d [ROB_SIZE];

    logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    // Registered outputs
    logic                 commit_valid_q, commit_valid_d;
    logic [4:0]           commit_rd_q, commit_rd_d;
    logic [31:0]          commit_value_q, commit_value_d;
    logic [ROB_WIDTH-1:0] commit_rob_id_q, commit_rob_id_d;
    logic                 store_commit_q, store_commit_d;
    logic [ROB_WIDTH-1:0] store_rob_id_q, store_rob_id_d;
    logic                 clear_q, clear_d;
    logic [31:0]          redirect_pc_q, redirect_pc_d;
    logic                 halted_q, halted_d;

    logic                 full;
    logic                 retire_en, mispredict, halt_retire, flush, issue_en;
    rob_kind_e            head_kind;
    logic [ROB_SIZE-1:0]  rs_hit, lsb_hit;
    lookup_t              qj_res, qk_res;

    assign full      = (count_q == FULL_COUNT);
    assign head_kind = rob_kind_e'(kind_q[head_q]);

    // A broadcast only lands on an entry that is still in flight.
    for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : g_hit
        assign rs_hit[gi]  = rs_ready  && busy_q[gi] && (rs_rob_id  == ROB_WIDTH'(gi));
        assign lsb_hit[gi] = lsb_ready && busy_q[gi] && (lsb_rob_id == ROB_WIDTH'(gi));
    end

    // Nothing retires during the flush cycle or once a halt has retired.
    assign retire_en   = !halted_q && !clear_q && busy_q[head_q] && ready_q[head_q];
    assign mispredict  = retire_en && (head_kind == ROB_KIND_BR) &&
                         (value_q[head_q] != pred_pc_q[head_q]);
    assign halt_retire = retire_en && (head_kind == ROB_KIND_HALT);
    // Flush both on the mispredicting retire edge and while clear is high.
    assign flush       = mispredict || clear_q;
    assign issue_en    = dec_ready && !full && !halted_q && !halt_retire && !flush;

    // Next-state: capture, retire, issue, then flush overrides entry state.
    always_comb begin
        busy_d    = busy_q;
        kind_d    = kind_q;
        rd_d      = rd_q;
        ready_d   = ready_q;
        value_d   = value_q;
        pred_pc_d = pred_pc_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + (ROB_WIDTH+1)'(issue_en) - (ROB_WIDTH+1)'(retire_en);

        commit_valid_d  = 1'b0;
        commit_rd_d     = commit_rd_q;
        commit_value_d  = commit_value_q;
        commit_rob_id_d = commit_rob_id_q;
        store_commit_d  = 1'b0;
        store_rob_id_d  = store_rob_id_q;
        clear_d         = 1'b0;
        redirect_pc_d   = redirect_pc_q;
        halted_d        = halted_q;

        for (int i = 0; i < ROB_SIZE; i++) begin
            if (rs_hit[i]) begin
                ready_d[i] = 1'b1;
                value_d[i] = rs_value;
            end
            if (lsb_hit[i]) begin
                ready_d[i] = 1'b1;
                value_d[i] = lsb_value;
            end
        end

        if (retire_en) begin
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + ROB_WIDTH'(1);
            case (head_kind)
                ROB_KIND_REG: begin
                    commit_valid_d  = 1'b1;
                    commit_rd_d     = rd_q[head_q];
                    commit_value_d  = value_q[head_q];
                    commit_rob_id_d = head_q;
                end
                ROB_KIND_ST: begin
                    store_commit_d = 1'b1;
                    store_rob_id_d = head_q;
                end
                ROB_KIND_BR: begin
                    if (mispredict) begin
                        clear_d       = 1'b1;
                        redirect_pc_d = value_q[head_q];
                    end
                end
                default: halted_d = 1'b1;
            endcase
        end

        if (issue_en) begin
            busy_d[tail_q]    = 1'b1;
            kind_d[tail_q]    = dec_kind;
            rd_d[tail_q]      = dec_rd;
            ready_d[tail_q]   = dec_value_ready || (dec_kind == ROB_KIND_HALT);
            value_d[tail_q]   = dec_value;
            pred_pc_d[tail_q] = dec_pred_pc;
            tail_d            = tail_q + ROB_WIDTH'(1);
        end

        if (flush) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy_d[i]  = 1'b0;
                ready_d[i] = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // State register; rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]    <= 1'b0;
                kind_q[i]    <= '0;
                rd_q[i]      <= '0;
                ready_q[i]   <= 1'b0;
                value_q[i]   <= '0;
                pred_pc_q[i] <= '0;
            end
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commit_valid_q  <= 1'b0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
            commit_rob_id_q <= '0;
            store_commit_q  <= 1'b0;
            store_rob_id_q  <= '0;
            clear_q         <= 1'b0;
            redirect_pc_q   <= '0;
            halted_q        <= 1'b0;
        end else if (rdy_in) begin
            busy_q          <= busy_d;
            kind_q          <= kind_d;
            rd_q            <= rd_d;
            ready_q         <= ready_d;
            value_q         <= value_d;
            pred_pc_q       <= pred_pc_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_valid_q  <= commit_valid_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
            commit_rob_id_q <= commit_rob_id_d;
            store_commit_q  <= store_commit_d;
            store_rob_id_q  <= store_rob_id_d;
            clear_q         <= clear_d;
            redirect_pc_q   <= redirect_pc_d;
            halted_q        <= halted_d;
        end
    end

    // Operand lookups with same-cycle broadcast bypass.
    always_comb begin
        qj_res = rob_lookup(qj_id, rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id,
                            lsb_value, ready_q[qj_id], value_q[qj_id]);
        qk_res = rob_lookup(qk_id, rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id,
                            lsb_value, ready_q[qk_id], value_q[qk_id]);
    end

    assign qj_ready      = qj_res.ready;
    assign qj_value      = qj_res.value;
    assign qk_ready      = qk_res.ready;
    assign qk_value      = qk_res.value;
    assign rob_full      = full;
    assign rob_tail      = tail_q;
    assign commit_valid  = commit_valid_q;
    assign commit_rd     = commit_rd_q;
    assign commit_value  = commit_value_q;
    assign commit_rob_id = commit_rob_id_q;
    assign store_commit  = store_commit_q;
    assign store_rob_id  = store_rob_id_q;
    assign clear         = clear_q;
    assign redirect_pc   = redirect_pc_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_rob.sv
// Directed testbench for the reorder buffer.
module tb_rob;
    import rob_pkg::*;

    logic                 clk_in = 1'b0;
    logic                 rst_n_in;
    logic                 rdy_in;
    logic                 rob_full;
    logic [ROB_WIDTH-1:0] rob_tail;
    logic                 dec_ready;
    logic [1:0]           dec_kind;
    logic [4:0]           dec_rd;
    logic [31:0]          dec_pred_pc;
    logic [31:0]          dec_value;
    logic                 dec_value_ready;
    logic                 rs_ready;
    logic [ROB_WIDTH-1:0] rs_rob_id;
    logic [31:0]          rs_value;
    logic                 lsb_ready;
    logic [ROB_WIDTH-1:0] lsb_rob_id;
    logic [31:0]          lsb_value;
    logic [ROB_WIDTH-1:0] qj_id, qk_id;
    logic                 qj_ready, qk_ready;
    logic [31:0]          qj_value, qk_value;
    logic                 commit_valid;
    logic [4:0]           commit_rd;
    logic [31:0]          commit_value;
    logic [ROB_WIDTH-1:0] commit_rob_id;
    logic                 store_commit;
    logic [ROB_WIDTH-1:0] store_rob_id;
    logic                 clear;
    logic [31:0]          redirect_pc;
    logic                 halted;

    int tests_run    = 0;
    int tests_failed = 0;

    rob dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .rob_full(rob_full), .rob_tail(rob_tail),
        .dec_ready(dec_ready), .dec_kind(dec_kind), .dec_rd(dec_rd),
        .dec_pred_pc(dec_pred_pc), .dec_value(dec_value), .dec_value_ready(dec_value_ready),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .qj_id(qj_id), .qk_id(qk_id), .qj_ready(qj_ready), .qk_ready(qk_ready),
        .qj_value(qj_value), .qk_value(qk_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_rob_id(commit_rob_id), .store_commit(store_commit), .store_rob_id(store_rob_id),
        .clear(clear), .redirect_pc(redirect_pc), .halted(halted)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        rst_n_in = 1'b0;
        #2;
        rst_n_in = 1'b1;
    endtask

    task automatic do_issue(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pred,
                            input logic [31:0] val, input logic vr);
        dec_ready = 1'b1; dec_kind = kind; dec_rd = rd;
        dec_pred_pc = pred; dec_value = val; dec_value_ready = vr;
        $display("[TB] issue kind=%0d rd=%0d at tail=%0d full=%0d", kind, rd, rob_tail, rob_full);
        tick();
        dec_ready = 1'b0; dec_value_ready = 1'b0;
    endtask

    task automatic do_rs(input logic [ROB_WIDTH-1:0] id, input logic [31:0] val);
        rs_ready = 1'b1; rs_rob_id = id; rs_value = val;
        $display("[TB] rs broadcast id=%0d value=0x%0h", id, val);
        tick();
        rs_ready = 1'b0;
    endtask

    task automatic do_lsb(input logic [ROB_WIDTH-1:0] id, input logic [31:0] val);
        lsb_ready = 1'b1; lsb_rob_id = id; lsb_value = val;
        $display("[TB] lsb broadcast id=%0d value=0x%0h", id, val);
        tick();
        lsb_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1;
        dec_ready = 0; dec_kind = 0; dec_rd = 0; dec_pred_pc = 0; dec_value = 0; dec_value_ready = 0;
        rs_ready = 0; rs_rob_id = 0; rs_value = 0;
        lsb_ready = 0; lsb_rob_id = 0; lsb_value = 0;
        qj_id = 0; qk_id = 0;
        #2;
        check_eq("reset_tail", 32'(rob_tail), 0);
        check_eq("reset_full", 32'(rob_full), 0);
        check_eq("reset_commit", 32'(commit_valid), 0);
        check_eq("reset_halted", 32'(halted), 0);
        check_eq("reset_clear", 32'(clear), 0);
        #1 rst_n_in = 1'b1;

        // Out-of-order completion, in-order retire
        do_issue(ROB_KIND_REG, 5'd1, 0, 0, 1'b0);
        do_issue(ROB_KIND_REG, 5'd2, 0, 0, 1'b0);
        do_issue(ROB_KIND_REG, 5'd3, 0, 0, 1'b0);
        check_eq("t1_tail", 32'(rob_tail), 3);
        do_rs(3'd2, 32'h22);
        do_rs(3'd0, 32'h00);
        check_eq("t1_no_commit_yet", 32'(commit_valid), 0);
        do_rs(3'd1, 32'h11);
        check_eq("t1_c0_valid", 32'(commit_valid), 1);
        check_eq("t1_c0_id", 32'(commit_rob_id), 0);
        check_eq("t1_c0_rd", 32'(commit_rd), 1);
        check_eq("t1_c0_val", commit_value, 32'h00);
        tick();
        check_eq("t1_c1_valid", 32'(commit_valid), 1);
        check_eq("t1_c1_id", 32'(commit_rob_id), 1);
        check_eq("t1_c1_rd", 32'(commit_rd), 2);
        check_eq("t1_c1_val", commit_value, 32'h11);
        tick();
        check_eq("t1_c2_valid", 32'(commit_valid), 1);
        check_eq("t1_c2_id", 32'(commit_rob_id), 2);
        check_eq("t1_c2_rd", 32'(commit_rd), 3);
        check_eq("t1_c2_val", commit_value, 32'h22);
        tick();
        check_eq("t1_pulse_end", 32'(commit_valid), 0);

        // Fill, ignore when full, wrap
        apply_reset();
        for (int i = 0; i < ROB_SIZE; i++) do_issue(ROB_KIND_REG, 5'(i + 8), 0, 0, 1'b0);
        check_eq("t2_full", 32'(rob_full), 1);
        check_eq("t2_tail_wrap", 32'(rob_tail), 0);
        do_issue(ROB_KIND_REG, 5'd30, 0, 32'hDEAD, 1'b1);
        check_eq("t2_ignored_tail", 32'(rob_tail), 0);
        check_eq("t2_ignored_full", 32'(rob_full), 1);
        do_rs(3'd0, 32'h5);
        check_eq("t2_still_full", 32'(rob_full), 1);
        tick();
        check_eq("t2_retire_valid", 32'(commit_valid), 1);
        check_eq("t2_retire_rd", 32'(commit_rd), 8);
        check_eq("t2_not_full", 32'(rob_full), 0);
        do_issue(ROB_KIND_REG, 5'd4, 0, 32'hAB, 1'b1);
        check_eq("t2_new_tail", 32'(rob_tail), 1);
        check_eq("t2_full_again", 32'(rob_full), 1);
        qj_id = 3'd0;
        #1;
        check_eq("t2_id0_ready", 32'(qj_ready), 1);
        check_eq("t2_id0_value", qj_value, 32'hAB);

        // Branch mispredict flush
        apply_reset();
        do_issue(ROB_KIND_BR, 5'd0, 32'h100, 0, 1'b0);
        do_issue(ROB_KIND_REG, 5'd7, 0, 0, 1'b0);
        do_rs(3'd0, 32'h200);
        lsb_ready = 1'b1; lsb_rob_id = 3'd1; lsb_value = 32'h55;
        tick();
        check_eq("t3_clear", 32'(clear), 1);
        check_eq("t3_redirect", redirect_pc, 32'h200);
        check_eq("t3_tail", 32'(rob_tail), 0);
        check_eq("t3_no_commit", 32'(commit_valid), 0);
        tick();
        lsb_ready = 1'b0;
        qj_id = 3'd1;
        #1;
        check_eq("t3_clear_pulse", 32'(clear), 0);
        check_eq("t3_younger_dropped", 32'(qj_ready), 0);
        check_eq("t3_tail_after", 32'(rob_tail), 0);
        do_issue(ROB_KIND_REG, 5'd9, 0, 32'h77, 1'b1);
        check_eq("t3_reissue_tail", 32'(rob_tail), 1);
        tick();
        check_eq("t3_post_commit", 32'(commit_valid), 1);
        check_eq("t3_post_id", 32'(commit_rob_id), 0);
        check_eq("t3_post_val", commit_value, 32'h77);

        // Same-cycle bypass on both broadcast ports
        apply_reset();
        for (int i = 0; i < 6; i++) do_issue(ROB_KIND_REG, 5'(i + 1), 0, 0, 1'b0);
        qj_id = 3'd4; qk_id = 3'd5;
        rs_ready = 1'b1; rs_rob_id = 3'd4; rs_value = 32'hAAAA;
        lsb_ready = 1'b1; lsb_rob_id = 3'd5; lsb_value = 32'hBBBB;
        #1;
        check_eq("t4_qj_ready", 32'(qj_ready), 1);
        check_eq("t4_qj_value", qj_value, 32'hAAAA);
        check_eq("t4_qk_ready", 32'(qk_ready), 1);
        check_eq("t4_qk_value", qk_value, 32'hBBBB);
        tick();
        rs_ready = 1'b0; lsb_ready = 1'b0;
        qj_id = 3'd3;
        #1;
        check_eq("t4_stored_qk", qk_value, 32'hBBBB);
        check_eq("t4_stored_qk_rdy", 32'(qk_ready), 1);
        check_eq("t4_pending_qj", 32'(qj_ready), 0);

        // Store release, freeze, halt
        apply_reset();
        do_issue(ROB_KIND_ST, 5'd0, 0, 0, 1'b0);
        do_lsb(3'd0, 32'h1234);
        tick();
        check_eq("t5_store_commit", 32'(store_commit), 1);
        check_eq("t5_store_id", 32'(store_rob_id), 0);
        check_eq("t5_no_reg_commit", 32'(commit_valid), 0);
        rdy_in = 1'b0;
        dec_ready = 1'b1; dec_kind = ROB_KIND_REG; dec_value_ready = 1'b1;
        tick(); tick(); tick();
        check_eq("t5_frozen_store", 32'(store_commit), 1);
        check_eq("t5_frozen_tail", 32'(rob_tail), 1);
        dec_ready = 1'b0; dec_value_ready = 1'b0;
        rdy_in = 1'b1;
        tick();
        check_eq("t5_store_pulse_end", 32'(store_commit), 0);
        check_eq("t5_tail_after", 32'(rob_tail), 1);
        do_issue(ROB_KIND_HALT, 5'd0, 0, 0, 1'b0);
        tick();
        check_eq("t5_halted", 32'(halted), 1);
        do_issue(ROB_KIND_REG, 5'd1, 0, 32'h1, 1'b1);
        check_eq("t5_halt_blocks_issue", 32'(rob_tail), 2);

        // Asynchronous reset mid-stream
        rst_n_in = 1'b0;
        #1;
        check_eq("t6_rst_halted", 32'(halted), 0);
        check_eq("t6_rst_tail", 32'(rob_tail), 0);
        check_eq("t6_rst_store", 32'(store_rob_id), 0);
        rst_n_in = 1'b1;
        do_issue(ROB_KIND_REG, 5'd3, 0, 32'h99, 1'b1);
        check_eq("t6_first_tail", 32'(rob_tail), 1);
        tick();
        check_eq("t6_first_commit", 32'(commit_valid), 1);
        check_eq("t6_first_id", 32'(commit_rob_id), 0);
        check_eq("t6_first_val", commit_value, 32'h99);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
